// File: rtl/data_memory_mc.sv
// Multi-cycle data memory with req/busy/done handshake and programmable wait states.
// Define DMEM_SUBWORD_EN to enable byte/halfword accesses; otherwise every access is a word.
module data_memory_mc #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic                  we,
   input  logic [1:0]            size,
   input  logic                  sign_ext,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [31:0]           rdata
);

   localparam int MIDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state, state_nx;
   logic [3:0]          cnt, cnt_nx;
   logic                busy_nx, done_nx, err_nx;
   logic                accept, commit, illegal;

   logic                we_q;
   logic [MIDX_W-1:0]   idx_q;
   logic [31:0]         wdata_q;
`ifdef DMEM_SUBWORD_EN
   logic [1:0]          size_q;
   logic [1:0]          off_q;
   logic                sext_q;
`else
   logic                unused_subword;
`endif

   logic [31:0]         mem [DEPTH_WORDS];
   logic [31:0]         rd_word;
   logic [31:0]         load_val;
   logic [31:0]         store_data;
   logic [3:0]          store_be;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      logic [63:0] widx;
      widx = 64'(a[ADDR_WIDTH-1:2]);
      return widx < 64'(DEPTH_WORDS);
   endfunction

`ifdef DMEM_SUBWORD_EN
   function automatic logic check_illegal(input logic [ADDR_WIDTH-1:0] a,
                                          input logic [1:0] sz);
      logic bad;
      case (sz)
         2'b00:   bad = 1'b0;
         2'b01:   bad = a[0];
         2'b10:   bad = (a[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad || !in_range(a);
   endfunction

   function automatic logic [31:0] ext_byte(input logic [7:0] v, input logic sx);
      logic signed [7:0]  s;
      logic signed [31:0] r;
      s = v;
      r = s;
      return sx ? r : {24'h0, v};
   endfunction

   function automatic logic [31:0] ext_half(input logic [15:0] v, input logic sx);
      logic signed [15:0] s;
      logic signed [31:0] r;
      s = v;
      r = s;
      return sx ? r : {16'h0, v};
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] off, input logic sx);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*off +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   return ext_byte(b, sx);
         2'b01:   return ext_half(h, sx);
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] store_mask(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         2'b00:   return 4'b0001 << off;
         2'b01:   return off[1] ? 4'b1100 : 4'b0011;
         2'b10:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Replicating the right-aligned data lets the byte mask alone pick the lanes.
   function automatic logic [31:0] store_align(input logic [1:0] sz, input logic [31:0] wd);
      case (sz)
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction
`else
   function automatic logic check_illegal(input logic [ADDR_WIDTH-1:0] a);
      return (a[1:0] != 2'b00) || !in_range(a);
   endfunction
`endif

   always_comb begin
`ifdef DMEM_SUBWORD_EN
      illegal = check_illegal(addr, size);
`else
      illegal = check_illegal(addr);
`endif
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      busy_nx  = busy;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      accept   = 1'b0;
      commit   = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               accept  = 1'b1;
               cnt_nx  = 4'(WAIT_STATES);
               busy_nx = 1'b1;
               if (illegal) begin
                  state_nx = RESP;
                  done_nx  = 1'b1;
                  err_nx   = 1'b1;
               end else begin
                  state_nx = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (cnt != 4'd0) begin
               cnt_nx = cnt - 4'd1;
            end else begin
               commit   = 1'b1;
               state_nx = RESP;
               done_nx  = 1'b1;
            end
         end
         RESP: begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
         end
         default: begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         rdata <= 32'h0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         busy  <= busy_nx;
         done  <= done_nx;
         err   <= err_nx;
         if (commit && !we_q) begin
            rdata <= load_val;
         end
      end
   end

   // Request capture: data-only registers, no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= we;
         idx_q   <= addr[MIDX_W+1:2];
         wdata_q <= wdata;
`ifdef DMEM_SUBWORD_EN
         size_q  <= size;
         off_q   <= addr[1:0];
         sext_q  <= sign_ext;
`endif
      end
   end

   always_comb begin
      rd_word = mem[idx_q];
`ifdef DMEM_SUBWORD_EN
      load_val   = load_extract(rd_word, size_q, off_q, sext_q);
      store_be   = store_mask(size_q, off_q);
      store_data = store_align(size_q, wdata_q);
`else
      load_val   = rd_word;
      store_be   = 4'b1111;
      store_data = wdata_q;
`endif
   end

`ifndef DMEM_SUBWORD_EN
   assign unused_subword = ^{size, sign_ext};
`endif

   // Reset wins at the commit edge, so a pending store is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && commit && we_q) begin
         for (int b = 0; b < 4; b++) begin
            if (store_be[b]) begin
               mem[idx_q][8*b +: 8] <= store_data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_memory_mc.sv
// Directed bench for data_memory_mc: one instance with two wait states, one with none.
module tb_data_memory_mc;

   logic        clk = 1'b0;
   logic        rst_n;
   int          total = 0;
   int          bad = 0;

   logic        req2, we2, sx2, busy2, done2, err2;
   logic [1:0]  sz2;
   logic [31:0] addr2, wd2, rdata2;
   logic        req0, we0, sx0, busy0, done0, err0;
   logic [1:0]  sz0;
   logic [31:0] addr0, wd0, rdata0;

   always #5 clk = ~clk;

   data_memory_mc #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req(req2), .we(we2), .size(sz2), .sign_ext(sx2),
      .addr(addr2), .wdata(wd2), .busy(busy2), .done(done2), .err(err2), .rdata(rdata2));

   data_memory_mc #(.ADDR_WIDTH(32), .DEPTH_WORDS(100), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .size(sz0), .sign_ext(sx0),
      .addr(addr0), .wdata(wd0), .busy(busy0), .done(done0), .err(err0), .rdata(rdata0));

   task automatic run2(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic e, output logic [31:0] rd);
      @(negedge clk);
      req2 = 1'b1; we2 = w; sz2 = sz; sx2 = sx; addr2 = a; wd2 = wd;
      @(posedge clk);
      @(negedge clk);
      req2 = 1'b0;
      lat = 1;
      while (!done2 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 50) lat = -1;
      e  = err2;
      rd = rdata2;
   endtask

   task automatic run0(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic e, output logic [31:0] rd);
      @(negedge clk);
      req0 = 1'b1; we0 = w; sz0 = 2'b10; sx0 = 1'b0; addr0 = a; wd0 = wd;
      @(posedge clk);
      @(negedge clk);
      req0 = 1'b0;
      lat = 1;
      while (!done0 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 50) lat = -1;
      e  = err0;
      rd = rdata0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      req2 = 1'b1; we2 = 1'b1; sz2 = 2'b10; sx2 = 1'b0; addr2 = 32'h0; wd2 = 32'h1;
      req0 = 1'b1; we0 = 1'b1; sz0 = 2'b10; sx0 = 1'b0; addr0 = 32'h0; wd0 = 32'h1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      total++; if ({busy2, done2, err2} !== 3'b000) begin bad++; $display("FAIL rst_ctrl2 got=%b want=000", {busy2, done2, err2}); end
      total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL rst_rdata2 got=%h want=00000000", rdata2); end
      total++; if ({busy0, done0, err0} !== 3'b000) begin bad++; $display("FAIL rst_ctrl0 got=%b want=000", {busy0, done0, err0}); end
      total++; if (rdata0 !== 32'h0) begin bad++; $display("FAIL rst_rdata0 got=%h want=00000000", rdata0); end
      req2 = 1'b0; req0 = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      total++; if ({busy2, busy0} !== 2'b00) begin bad++; $display("FAIL rst_noaccept got=%b want=00", {busy2, busy0}); end
   endtask

   task automatic test_word;
      int lat; logic e; logic [31:0] rd;
      run2(1'b1, 2'b10, 1'b0, 32'h18, 32'd151, lat, e, rd);
      total++; if (lat !== 4) begin bad++; $display("FAIL st_lat got=%0d want=4", lat); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL st_err got=%b want=0", e); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL st_rdata_hold got=%h want=00000000", rd); end
      run2(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, lat, e, rd);
      total++; if (lat !== 4) begin bad++; $display("FAIL ld_lat got=%0d want=4", lat); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL ld_err got=%b want=0", e); end
      total++; if (rd !== 32'h00000097) begin bad++; $display("FAIL ld_word got=%h want=00000097", rd); end
   endtask

`ifdef DMEM_SUBWORD_EN
   task automatic test_subword;
      int lat; logic e; logic [31:0] rd;
      run2(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, lat, e, rd);
      run2(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, e, rd);
      total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_signed got=%h want=ffffff80", rd); end
      run2(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, e, rd);
      total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lb_unsigned got=%h want=00000080", rd); end
      run2(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, e, rd);
      total++; if (rd !== 32'hFFFF80FF) begin bad++; $display("FAIL lh_signed got=%h want=ffff80ff", rd); end
      run2(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, e, rd);
      total++; if (rd !== 32'h00007F01) begin bad++; $display("FAIL lh_unsigned got=%h want=00007f01", rd); end
      run2(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, lat, e, rd);
      run2(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, e, rd);
      total++; if (rd !== 32'h80FF5501) begin bad++; $display("FAIL sb_merge got=%h want=80ff5501", rd); end
      run2(1'b1, 2'b01, 1'b0, 32'h12, 32'hBBBB1234, lat, e, rd);
      run2(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, rd);
      total++; if (rd !== 32'h12345501) begin bad++; $display("FAIL sh_merge got=%h want=12345501", rd); end
      run2(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, e, rd);
      total++; if ({lat, e} !== {32'd1, 1'b1}) begin bad++; $display("FAIL lh_misalign got lat=%0d err=%b want lat=1 err=1", lat, e); end
      run2(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, e, rd);
      total++; if ({lat, e} !== {32'd1, 1'b1}) begin bad++; $display("FAIL size_rsvd got lat=%0d err=%b want lat=1 err=1", lat, e); end
      total++; if (rd !== 32'h12345501) begin bad++; $display("FAIL rsvd_rdata got=%h want=12345501", rd); end
   endtask
`else
   task automatic test_wordonly;
      int lat; logic e; logic [31:0] rd;
      run2(1'b1, 2'b00, 1'b0, 32'h10, 32'h80FF7F01, lat, e, rd);
      total++; if (e !== 1'b0) begin bad++; $display("FAIL wo_store_err got=%b want=0", e); end
      run2(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, lat, e, rd);
      total++; if (rd !== 32'h80FF7F01) begin bad++; $display("FAIL wo_load got=%h want=80ff7f01", rd); end
      run2(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, e, rd);
      total++; if ({lat, e} !== {32'd4, 1'b0}) begin bad++; $display("FAIL wo_size_ign got lat=%0d err=%b want lat=4 err=0", lat, e); end
      run2(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, e, rd);
      total++; if ({lat, e} !== {32'd1, 1'b1}) begin bad++; $display("FAIL wo_misalign got lat=%0d err=%b want lat=1 err=1", lat, e); end
   endtask
`endif

   task automatic test_errors;
      int lat; logic e; logic [31:0] rd;
      run2(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, lat, e, rd);
      run2(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, e, rd);
      total++; if ({lat, e} !== {32'd1, 1'b1}) begin bad++; $display("FAIL lw_misalign got lat=%0d err=%b want lat=1 err=1", lat, e); end
      total++; if (rd !== 32'h00000097) begin bad++; $display("FAIL err_rdata got=%h want=00000097", rd); end
      run2(1'b1, 2'b10, 1'b0, 32'h0, 32'h0BADF00D, lat, e, rd);
      run2(1'b1, 2'b10, 1'b0, 32'd1024, 32'hFFFFFFFF, lat, e, rd);
      total++; if ({lat, e} !== {32'd1, 1'b1}) begin bad++; $display("FAIL sw_range got lat=%0d err=%b want lat=1 err=1", lat, e); end
      run2(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, e, rd);
      total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL range_nowrite got=%h want=0badf00d", rd); end
      run0(1'b1, 32'd400, 32'h11111111, lat, e, rd);
      total++; if ({lat, e} !== {32'd1, 1'b1}) begin bad++; $display("FAIL d0_range got lat=%0d err=%b want lat=1 err=1", lat, e); end
      run0(1'b1, 32'd396, 32'hCAFE0396, lat, e, rd);
      total++; if ({lat, e} !== {32'd2, 1'b0}) begin bad++; $display("FAIL d0_last_st got lat=%0d err=%b want lat=2 err=0", lat, e); end
      run0(1'b0, 32'd396, 32'h0, lat, e, rd);
      total++; if (rd !== 32'hCAFE0396) begin bad++; $display("FAIL d0_last_ld got=%h want=cafe0396", rd); end
   endtask

   task automatic test_back_to_back;
      int lat; logic e; logic [31:0] rd;
      logic exp_b, exp_d;
      run0(1'b1, 32'h0, 32'hA5A50F0F, lat, e, rd);
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; sz0 = 2'b10; sx0 = 1'b0; addr0 = 32'h0;
      @(posedge clk);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         exp_b = (i % 3) != 2;
         exp_d = (i % 3) == 1;
         total++; if (busy0 !== exp_b) begin bad++; $display("FAIL b2b_busy[%0d] got=%b want=%b", i, busy0, exp_b); end
         total++; if (done0 !== exp_d) begin bad++; $display("FAIL b2b_done[%0d] got=%b want=%b", i, done0, exp_d); end
      end
      req0 = 1'b0;
      total++; if (rdata0 !== 32'hA5A50F0F) begin bad++; $display("FAIL b2b_rdata got=%h want=a5a50f0f", rdata0); end
      @(negedge clk);
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL b2b_release got=%b want=0", busy0); end
   endtask

   task automatic test_reset_commit;
      int lat; logic e; logic [31:0] rd;
      run2(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, lat, e, rd);
      @(negedge clk);
      req2 = 1'b1; we2 = 1'b1; sz2 = 2'b10; sx2 = 1'b0; addr2 = 32'h20; wd2 = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      req2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total++; if ({busy2, done2, err2} !== 3'b000) begin bad++; $display("FAIL rc_ctrl got=%b want=000", {busy2, done2, err2}); end
      total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL rc_rdata got=%h want=00000000", rdata2); end
      rst_n = 1'b1;
      run2(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, e, rd);
      total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL rc_dropped got=%h want=12345678", rd); end
   endtask

   initial begin
      test_reset();
      test_word();
`ifdef DMEM_SUBWORD_EN
      test_subword();
`else
      test_wordonly();
`endif
      test_errors();
      test_back_to_back();
      test_reset_commit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
